prog_loader: RTL
================

Name: prog_loader

Overview:
Boot-time program loader that sits directly upstream of the single-cycle MIPS CPU. It receives a byte stream over a valid/ready interface and assembles big-endian 32-bit words. It writes those words into instruction memory through a dedicated write port and holds the CPU in reset until a complete, checksum-verified image has been loaded. It replaces file-based memory preloading when the design is built for hardware.

Parameters:
ADDR_WIDTH, 8, width of the instruction-memory word address.
MAX_WORDS, 256, largest accepted image length in words; must be <= 2**ADDR_WIDTH.
BASE_ADDR, 0, word address where the first image word is written.

Ports:
clock  input  1  system clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
in_data  input  8  stream byte.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid and in_ready are both high.
start  input  1  single-cycle pulse that re-arms the loader from DONE or ERROR.
mem_we  output  1  instruction-memory write strobe, one cycle per word.
mem_addr  output  ADDR_WIDTH  word address for the write.
mem_wdata  output  32  word to write.
cpu_hold  output  1  drives the CPU reset; high = CPU held in reset.
done  output  1  image loaded and verified.
error  output  1  image rejected.

Behaviour:
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words of 4 bytes each (MSB first), then 1 checksum byte.
- Checksum rule: the XOR of every preceding frame byte, including both length bytes.
- States: LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR.
- Reset state is LEN_HI. On reset:
  - mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - cpu_hold=1, done=0, error=0, in_ready=1.
  - Word counter, byte counter and running XOR cleared.
- in_ready is high in LEN_HI, LEN_LO, DATA and CHECK; low in DONE and ERROR.
- LEN_HI: on transfer, latch the high length byte and go to LEN_LO.
- LEN_LO: on transfer, form N and evaluate:
  - N > MAX_WORDS: go to ERROR.
  - N == 0: go to CHECK.
  - otherwise: go to DATA.
- DATA: a 2-bit byte index selects the shift position, MSB first.
  - On the 4th byte transfer, the next cycle has mem_we=1, mem_wdata=assembled word, mem_addr=BASE_ADDR+word index.
  - Write latency is 1 cycle after the accepting edge. mem_we is high for exactly one cycle per word.
  - mem_addr and mem_wdata hold their values after the strobe until the next write.
  - Back-to-back bytes are accepted every cycle with no stalls.
  - Address arithmetic wraps modulo 2**ADDR_WIDTH.
  - After word N-1 is written, go to CHECK.
- CHECK: on transfer, compare the byte with the running XOR.
  - Match: go to DONE.
  - Mismatch: go to ERROR.
- DONE: done=1, cpu_hold=0, so the CPU starts fetching on the next cycle.
- ERROR: error=1, cpu_hold=1. Words already written stay in memory; this block does not roll them back.
- start in DONE or ERROR:
  - Next state is LEN_HI.
  - done and error clear, cpu_hold=1, counters and XOR cleared.
- start in any other state is ignored.
- in_valid while in_ready=0: no transfer, no state change.
- reset mid-frame: all state returns to reset values on the next edge. A pending mem_we is cancelled.
- done and error are never both high.
- cpu_hold is high in every state except DONE.

Test Plan:
- Normal load, BASE_ADDR=0: bytes 00 02 20 08 00 05 01 09 40 20 47 sent one per cycle. Required response:
  - Writes (addr0, 0x20080005) and (addr1, 0x01094020), each strobe 1 cycle after its 4th byte.
  - done=1, cpu_hold=0, in_ready=0.
- Bad checksum: same frame with final byte 46 -> both words written, error=1, done=0, cpu_hold stays 1.
- Oversize length with MAX_WORDS=256: bytes 01 01 -> ERROR right after LEN_LO, no mem_we ever, in_ready=0.
- Zero-length frame: bytes 00 00 00 -> no writes, done=1. Then a start pulse -> done=0, cpu_hold=1, in_ready=1, state LEN_HI.
- Gapped stream: in_valid toggled randomly during the normal-load frame -> identical writes and result; no extra or duplicate mem_we.
- reset asserted for 1 cycle after the 6th byte of the normal-load frame:
  - Pending write dropped.
  - A full resend of the normal-load frame then produces exactly two writes and done=1.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time image loader: assembles big-endian words from a byte stream, writes them
// to instruction memory and keeps the CPU in reset until the image checksum verifies.
//
// state   | meaning
// LEN_HI  | waiting for high byte of the word count
// LEN_LO  | waiting for low byte; decides oversize / empty / data
// DATA    | collecting 4 bytes per word, one memory write per word
// CHECK   | waiting for the XOR checksum byte
// DONE    | image verified, CPU released
// ERROR   | image rejected, CPU held; only start re-arms
module prog_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  start,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] L_BASE = ADDR_WIDTH'(BASE_ADDR);

  state_t                r_state;
  state_t                w_next;
  logic [7:0]            r_len_hi;
  logic [15:0]           r_len;
  logic [15:0]           r_word_cnt;
  logic [1:0]            r_byte_idx;
  logic [23:0]           r_shift;
  logic [7:0]            r_xor;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;

  logic        w_xfer;
  logic [15:0] w_len_n;
  logic        w_oversize;
  logic        w_zero;
  logic        w_word_end;
  logic        w_last_word;
  logic        w_rearm;

  assign w_xfer      = in_valid & in_ready;
  assign w_len_n     = {r_len_hi, in_data};
  assign w_oversize  = {16'd0, w_len_n} > 32'(MAX_WORDS);
  assign w_zero      = (w_len_n == 16'd0);
  assign w_word_end  = (r_byte_idx == 2'd3);
  assign w_last_word = (r_word_cnt == r_len - 16'd1);
  assign w_rearm     = start & ((r_state == S_DONE) | (r_state == S_ERROR));

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_LEN_HI;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LEN_HI: if (w_xfer) w_next = S_LEN_LO;
      S_LEN_LO: begin
        if (w_xfer) begin
          if (w_oversize)  w_next = S_ERROR;
          else if (w_zero) w_next = S_CHECK;
          else             w_next = S_DATA;
        end
      end
      S_DATA:   if (w_xfer && w_word_end && w_last_word) w_next = S_CHECK;
      S_CHECK:  if (w_xfer) w_next = (in_data == r_xor) ? S_DONE : S_ERROR;
      S_DONE:   if (start) w_next = S_LEN_HI;
      S_ERROR:  if (start) w_next = S_LEN_HI;
      default:  w_next = S_LEN_HI;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (r_state)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK: in_ready = 1'b1;
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERROR: error = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Word index and running XOR; the strobe is a one-cycle pulse registered off the 4th byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_len_hi    <= 8'd0;
      r_len       <= 16'd0;
      r_word_cnt  <= 16'd0;
      r_byte_idx  <= 2'd0;
      r_shift     <= 24'd0;
      r_xor       <= 8'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= L_BASE;
      r_mem_wdata <= 32'd0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_rearm) begin
        r_len_hi   <= 8'd0;
        r_len      <= 16'd0;
        r_word_cnt <= 16'd0;
        r_byte_idx <= 2'd0;
        r_xor      <= 8'd0;
      end else if (w_xfer) begin
        r_xor <= r_xor ^ in_data;
        case (r_state)
          S_LEN_HI: r_len_hi <= in_data;
          S_LEN_LO: begin
            r_len      <= w_len_n;
            r_word_cnt <= 16'd0;
            r_byte_idx <= 2'd0;
          end
          S_DATA: begin
            r_byte_idx <= r_byte_idx + 2'd1;
            if (w_word_end) begin
              r_mem_we    <= 1'b1;
              r_mem_wdata <= {r_shift, in_data};
              r_mem_addr  <= L_BASE + r_word_cnt[ADDR_WIDTH-1:0];
              r_word_cnt  <= r_word_cnt + 16'd1;
            end else begin
              r_shift <= {r_shift[15:0], in_data};
            end
          end
          default: r_len_hi <= r_len_hi;
        endcase
      end
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
